// File: rtl/data_mem_responder.sv
// Word-organised data memory acting as the load/store responder for the CPU MEM stage.
// One request at a time over valid/ready, answered after LATENCY wait states.
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  generate
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be within 0..15");
    end
    if (ADDR_W < 1 || ADDR_W > 30) begin : g_bad_addr_w
      $error("data_mem_responder: ADDR_W must be within 1..30");
    end
  endgenerate

  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_count;
  logic [3:0]        w_count_next;
  logic              r_err;
  logic              r_rd_ok;
  logic              w_accept;
  logic              w_err;
  logic              w_store;
  logic              w_load;
  logic [ADDR_W-1:0] w_word;
  logic [31:0]       w_rd_word;

  // A request seen while rst is high must never touch memory.
  assign w_accept = (r_state == IDLE) && req_valid && !rst;
  assign w_err    = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_W + 2)) != 32'd0);
  assign w_word   = req_addr[ADDR_W+1:2];
  assign w_store  = w_accept && req_we && !w_err;
  assign w_load   = w_accept && !req_we && !w_err;

  // One byte-wide array per lane gives byte-enabled writes with a registered read port.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [2**ADDR_W];
      logic [7:0] r_lane_q;

      always_ff @(posedge clk) begin
        if (w_store && req_wstrb[gi]) begin
          r_lane[w_word] <= req_wdata[8*gi +: 8];
        end
        if (w_load) begin
          r_lane_q <= r_lane[w_word];
        end
      end

      assign w_rd_word[8*gi +: 8] = r_lane_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= 4'd0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_accept) begin
        r_err   <= w_err;
        r_rd_ok <= !req_we && !w_err;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY > 0) begin
            w_state_next = WAIT;
            w_count_next = LAT_M1;
          end else begin
            w_state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (r_count == 4'd0) begin
          w_state_next = RESP;
        end else begin
          w_count_next = r_count - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  // Stores, errors and the post-reset state all read back as zero.
  assign rsp_rdata = r_rd_ok ? w_rd_word : 32'd0;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder with three instances at LATENCY 2, 0 and 5.
module tb_data_mem_responder;

  localparam int ADDR_W = 10;
  localparam int N = 3;
  localparam int LATS [N] = '{2, 0, 5};

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_we    [N];
  logic [31:0] req_addr  [N];
  logic [31:0] req_wdata [N];
  logic [3:0]  req_wstrb [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_rdata [N];
  logic        rsp_err   [N];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        sb [$];
  bit   [31:0] mdl [int];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      data_mem_responder #(
        .ADDR_W (ADDR_W),
        .LATENCY(LATS[gi])
      ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid[gi]),
        .req_ready(req_ready[gi]),
        .req_we   (req_we[gi]),
        .req_addr (req_addr[gi]),
        .req_wdata(req_wdata[gi]),
        .req_wstrb(req_wstrb[gi]),
        .rsp_valid(rsp_valid[gi]),
        .rsp_ready(rsp_ready[gi]),
        .rsp_rdata(rsp_rdata[gi]),
        .rsp_err  (rsp_err[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected response for one request, also updating the memory model for good stores.
  task automatic model_req(input int k, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    rsp_t        e;
    bit          err;
    int          key;
    logic [31:0] w;
    err = (addr[1:0] != 2'b00) || (addr >= (32'd1 << (ADDR_W + 2)));
    key = k * 65536 + int'(addr[ADDR_W+1:2]);
    e.err   = err;
    e.rdata = 32'd0;
    if (!err && we) begin
      w = mdl.exists(key) ? mdl[key] : 32'd0;
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      end
      mdl[key] = w;
    end else if (!err) begin
      e.rdata = mdl[key];
    end
    sb.push_back(e);
  endtask

  task automatic send(input int k, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input int hold);
    rsp_t        e;
    int          cnt;
    bit          rdy_ok;
    logic [31:0] held;
    @(negedge clk);
    check($sformatf("i%0d_ready_before_%h", k, addr), req_ready[k], 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wstrb[k] = strb;
    model_req(k, we, addr, wdata, strb);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    cnt    = 0;
    rdy_ok = 1'b1;
    while (rsp_valid[k] !== 1'b1 && cnt < 40) begin
      if (req_ready[k] !== 1'b0) rdy_ok = 1'b0;
      @(posedge clk);
      #1;
      cnt++;
    end
    check($sformatf("i%0d_latency_%h", k, addr), cnt, LATS[k]);
    check($sformatf("i%0d_ready_low_wait_%h", k, addr), rdy_ok, 32'd1);
    check($sformatf("i%0d_ready_low_resp_%h", k, addr), req_ready[k], 32'd0);
    e = sb.pop_front();
    check($sformatf("i%0d_rdata_%h", k, addr), rsp_rdata[k], e.rdata);
    check($sformatf("i%0d_err_%h", k, addr), rsp_err[k], e.err);
    held = rsp_rdata[k];
    // Backpressure: toggle a stray store request while the response is stalled.
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("i%0d_bp_valid_%0d", k, i), rsp_valid[k], 32'd1);
      check($sformatf("i%0d_bp_rdata_%0d", k, i), rsp_rdata[k], held);
      check($sformatf("i%0d_bp_ready_%0d", k, i), req_ready[k], 32'd0);
      req_valid[k] = ~req_valid[k];
      req_we[k]    = 1'b1;
      req_addr[k]  = 32'h10;
      req_wdata[k] = 32'hFFFF_FFFF;
      req_wstrb[k] = 4'hF;
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    check($sformatf("i%0d_valid_after_hs_%h", k, addr), rsp_valid[k], 32'd0);
    check($sformatf("i%0d_ready_after_hs_%h", k, addr), req_ready[k], 32'd1);
    check($sformatf("i%0d_rdata_hold_%h", k, addr), rsp_rdata[k], e.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rsp_t e;
    bit   seen;
    bit   exp_v;
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
      req_wstrb[k] = 4'd0;
      rsp_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      check($sformatf("i%0d_rst_ready", k), req_ready[k], 32'd1);
      check($sformatf("i%0d_rst_valid", k), rsp_valid[k], 32'd0);
      check($sformatf("i%0d_rst_rdata", k), rsp_rdata[k], 32'd0);
      check($sformatf("i%0d_rst_err", k), rsp_err[k], 32'd0);
    end

    // Basic store/load and byte masking
    send(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    send(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    send(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0);
    send(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 0);
    send(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

    // Error accesses must leave memory untouched
    send(0, 1'b0, 32'h22, 32'h0, 4'h0, 0);
    send(0, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 0);
    send(0, 1'b1, 32'h1020, 32'h1234_5678, 4'hF, 0);
    send(0, 1'b1, 32'h21, 32'h1234_5678, 4'hF, 0);
    send(0, 1'b1, 32'h20, 32'hCAFE_F00D, 4'h5, 0);
    send(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

    // wstrb=0 store is a no-op
    send(0, 1'b1, 32'h30, 32'h0BAD_CAFE, 4'hF, 0);
    send(0, 1'b1, 32'h30, 32'h5555_5555, 4'h0, 0);
    send(0, 1'b0, 32'h30, 32'h0, 4'h0, 0);

    // Backpressure on a load, then confirm stray stores were ignored
    send(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
    send(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);

    // LATENCY=0 back-to-back with req_valid held high
    @(negedge clk);
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 32'h40;
    req_wdata[1] = 32'h100;
    req_wstrb[1] = 4'hF;
    model_req(1, 1'b1, 32'h40, 32'h100, 4'hF);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      exp_v = (c % 2 == 0);
      check($sformatf("b2b_valid_%0d", c), rsp_valid[1], exp_v);
      check($sformatf("b2b_ready_%0d", c), req_ready[1], !exp_v);
      if (rsp_valid[1] === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("b2b_err_%0d", c), rsp_err[1], e.err);
      end
      if (!exp_v) begin
        if (c < 5) begin
          req_wdata[1] = 32'h100 + 32'(c);
          model_req(1, 1'b1, 32'h40, req_wdata[1], 4'hF);
        end else begin
          req_valid[1] = 1'b0;
          rsp_ready[1] = 1'b0;
        end
      end
    end
    check("b2b_sb_drained", sb.size(), 32'd0);
    sb.delete();
    send(1, 1'b0, 32'h40, 32'h0, 4'h0, 0);

    // Reset during WAIT at LATENCY=5, with a request on an idle instance during rst
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h8;
    req_wdata[2] = 32'h0000_ABCD;
    req_wstrb[2] = 4'hF;
    model_req(2, 1'b1, 32'h8, 32'h0000_ABCD, 4'hF);
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    check("rst_mid_accepted", req_ready[2], 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'hFFFF_FFFF;
    req_wstrb[0] = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid[0] = 1'b0;
    check("rst_mid_ready", req_ready[2], 32'd1);
    check("rst_mid_valid", rsp_valid[2], 32'd0);
    check("rst_mid_rdata", rsp_rdata[2], 32'd0);
    check("rst_mid_err", rsp_err[2], 32'd0);
    check("rst_req_ignored_ready", req_ready[0], 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid[2] !== 1'b0) seen = 1'b1;
    end
    check("rst_mid_no_resp", seen, 32'd0);
    send(2, 1'b0, 32'h8, 32'h0, 4'h0, 0);
    send(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
